dmw_xlate_ctrl: RTL and testbench

DMW_XLATE_CTRL -- requirements
Module: dmw_xlate_ctrl

---
 rtl/dmw_xlate_ctrl_pkg.sv | 31 +++
 rtl/dmw_xlate_ctrl_match.sv | 30 +++
 rtl/dmw_xlate_ctrl.sv | 128 ++++++++++++
 tb/tb_dmw_xlate_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmw_xlate_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// dmw_xlate_ctrl_pkg : FSM states and DMW CSR field positions
// Rev 1.0
// ----------------------------------------------------------------
package dmw_xlate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GRANT = 2'd2
  } xlate_state_e;

  // Bit positions shared with the DMW CSR register implementation
  localparam int C_DMW_VSEG_HI = 31;
  localparam int C_DMW_VSEG_LO = 29;
  localparam int C_DMW_PSEG_HI = 27;
  localparam int C_DMW_PSEG_LO = 25;
  localparam int C_DMW_MAT_HI  = 5;
  localparam int C_DMW_MAT_LO  = 4;
  localparam int C_DMW_PLV3    = 3;
  localparam int C_DMW_PLV0    = 0;

  typedef struct packed {
    logic        hit;
    logic [1:0]  mat;
    logic [31:0] paddr;
  } xlate_res_t;

endpackage
`default_nettype wire

// File: rtl/dmw_xlate_ctrl_match.sv
`default_nettype none
// ----------------------------------------------------------------
// dmw_match : evaluates one direct-mapped window against a vaddr
// Rev 1.0
// ----------------------------------------------------------------
module dmw_match
  import dmw_xlate_ctrl_pkg::*;
(
  input  logic [31:0] dmw,
  input  logic [31:0] vaddr,
  input  logic [1:0]  plv,
  output logic        hit,
  output logic [31:0] paddr,
  output logic [1:0]  mat
);

  logic w_plv_ok;
  logic w_unused;

  // Only PLV0 and PLV3 have enable bits; PLV1/2 can never use a window
  assign w_plv_ok = ((plv == 2'd0) && dmw[C_DMW_PLV0]) ||
                    ((plv == 2'd3) && dmw[C_DMW_PLV3]);
  assign hit      = (vaddr[31:29] == dmw[C_DMW_VSEG_HI:C_DMW_VSEG_LO]) && w_plv_ok;
  assign paddr    = {dmw[C_DMW_PSEG_HI:C_DMW_PSEG_LO], vaddr[28:0]};
  assign mat      = dmw[C_DMW_MAT_HI:C_DMW_MAT_LO];

  assign w_unused = ^{dmw[28], dmw[24:6], dmw[2:1]};

endmodule
`default_nettype wire

// File: rtl/dmw_xlate_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// dmw_xlate_ctrl : DA/DMW translation with CSR-write drain/grant
// Rev 1.0
// ----------------------------------------------------------------
module dmw_xlate_ctrl
  import dmw_xlate_ctrl_pkg::*;
#(
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_vaddr,
  input  logic                  crmd_da,
  input  logic                  crmd_pg,
  input  logic [1:0]            crmd_plv,
  input  logic [31:0]           dmw0,
  input  logic [31:0]           dmw1,
  input  logic                  csr_wr_req,
  output logic                  csr_wr_grant,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_paddr,
  output logic [1:0]            resp_mat,
  output logic                  resp_hit,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  xlate_state_e          r_state;
  xlate_state_e          w_state_nxt;
  logic                  w_grant;
  logic                  w_accept;
  logic                  r_resp_valid;
  xlate_res_t            r_resp;
  xlate_res_t            w_res;
  logic [MISS_CNT_W-1:0] r_miss_cnt;
  logic [31:0]           w_dmw       [2];
  logic [1:0]            w_win_hit;
  logic [31:0]           w_win_paddr [2];
  logic [1:0]            w_win_mat   [2];
  logic                  w_unused;

  assign w_dmw[0] = dmw0;
  assign w_dmw[1] = dmw1;
  assign w_unused = crmd_pg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dmw
    dmw_match u_match (
      .dmw   (w_dmw[gi]),
      .vaddr (req_vaddr),
      .plv   (crmd_plv),
      .hit   (w_win_hit[gi]),
      .paddr (w_win_paddr[gi]),
      .mat   (w_win_mat[gi])
    );
  end

  always_comb begin
    w_res.hit   = 1'b0;
    w_res.mat   = 2'b00;
    w_res.paddr = req_vaddr;
    if (crmd_da) begin
      w_res.hit = 1'b1;
    end else if (w_win_hit[0]) begin
      w_res.hit   = 1'b1;
      w_res.mat   = w_win_mat[0];
      w_res.paddr = w_win_paddr[0];
    end else if (w_win_hit[1]) begin
      w_res.hit   = 1'b1;
      w_res.mat   = w_win_mat[1];
      w_res.paddr = w_win_paddr[1];
    end
  end

  // A pending CSR write blocks new requests so in-flight work uses old CSRs
  assign req_ready = (r_state == RUN) && !csr_wr_req && (!r_resp_valid || resp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      RUN:     if (csr_wr_req) w_state_nxt = DRAIN;
      DRAIN:   if (!r_resp_valid || resp_ready) w_state_nxt = GRANT;
      GRANT: begin
        w_grant     = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp       <= w_res;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
    end else if (w_accept && !w_res.hit && (r_miss_cnt != {MISS_CNT_W{1'b1}})) begin
      r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
    end
  end

  assign csr_wr_grant = w_grant;
  assign resp_valid   = r_resp_valid;
  assign resp_paddr   = r_resp.paddr;
  assign resp_mat     = r_resp.mat;
  assign resp_hit     = r_resp.hit;
  assign miss_cnt     = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmw_xlate_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_dmw_xlate_ctrl : directed + randomized checks against a model
// Rev 1.0
// ----------------------------------------------------------------
module tb_dmw_xlate_ctrl;

  localparam int MW       = 2;
  localparam int MISS_MAX = (1 << MW) - 1;

  typedef struct packed {
    logic        hit;
    logic [1:0]  mat;
    logic [31:0] paddr;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_vaddr = '0;
  logic          crmd_da = 1'b0;
  logic          crmd_pg = 1'b0;
  logic [1:0]    crmd_plv = '0;
  logic [31:0]   dmw0 = '0;
  logic [31:0]   dmw1 = '0;
  logic          csr_wr_req = 1'b0;
  logic          csr_wr_grant;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_paddr;
  logic [1:0]    resp_mat;
  logic          resp_hit;
  logic [MW-1:0] miss_cnt;

  int   total = 0;
  int   bad = 0;
  int   exp_miss = 0;
  res_t last_exp;

  dmw_xlate_ctrl #(.MISS_CNT_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_plv(crmd_plv),
    .dmw0(dmw0), .dmw1(dmw1), .csr_wr_req(csr_wr_req), .csr_wr_grant(csr_wr_grant),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_mat(resp_mat), .resp_hit(resp_hit), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Window selection done with plain shifts/masks over an ordered window list
  function automatic res_t ref_xlate(input logic [31:0] va, input logic da,
                                     input logic [1:0] plv, input logic [31:0] w0,
                                     input logic [31:0] w1);
    res_t        r;
    logic [31:0] win [2];
    win[0] = w0;
    win[1] = w1;
    r.hit = 1'b0; r.mat = 2'b00; r.paddr = va;
    if (da) begin
      r.hit = 1'b1;
      return r;
    end
    for (int n = 0; n < 2; n++) begin
      if (((va >> 29) == (win[n] >> 29)) &&
          ((plv == 2'd0 && win[n][0]) || (plv == 2'd3 && win[n][3]))) begin
        r.hit   = 1'b1;
        r.mat   = 2'((win[n] >> 4) & 32'd3);
        r.paddr = (((win[n] >> 25) & 32'd7) << 29) | (va & 32'h1FFF_FFFF);
        return r;
      end
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] va, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1;
    req_vaddr = va;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        last_exp = ref_xlate(va, crmd_da, crmd_plv, dmw0, dmw1);
        if (!last_exp.hit && exp_miss < MISS_MAX) exp_miss++;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0 || csr_wr_grant !== 1'b0) begin bad++; $display("FAIL reset_held: valid=%0b grant=%0b want 0 0", resp_valid, csr_wr_grant); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (resp_paddr !== 32'h0 || resp_mat !== 2'b00 || resp_hit !== 1'b0) begin bad++; $display("FAIL reset_resp: paddr=%h mat=%0d hit=%0b want 0", resp_paddr, resp_mat, resp_hit); end
    total++; if (miss_cnt !== '0) begin bad++; $display("FAIL reset_miss: got %0d want 0", miss_cnt); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    exp_miss = 0;
  endtask

  task automatic test_da();
    bit ok;
    crmd_da = 1'b1; crmd_pg = 1'b0; resp_ready = 1'b1;
    dmw0 = 32'h0000_0009; dmw1 = 32'h0000_0009;
    send(32'h1234_5678, ok);
    total++; if (!ok) begin bad++; $display("FAIL da_accept: not accepted within budget"); end
    total++; if (resp_valid !== 1'b1 || resp_paddr !== 32'h1234_5678 || resp_hit !== 1'b1 || resp_mat !== 2'b00) begin bad++; $display("FAIL da_resp: v=%0b paddr=%h hit=%0b mat=%0d want 1 12345678 1 0", resp_valid, resp_paddr, resp_hit, resp_mat); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL da_consume: valid=%0b want 0", resp_valid); end
  endtask

  task automatic test_dmw_hit();
    bit ok;
    crmd_da = 1'b0; crmd_pg = 1'b1; crmd_plv = 2'd0;
    dmw0 = 32'hA000_0011; dmw1 = 32'h0;
    send(32'hB000_0040, ok);
    total++; if (!ok || resp_paddr !== 32'h1000_0040 || resp_mat !== 2'd1 || resp_hit !== 1'b1) begin bad++; $display("FAIL dmw_hit: ok=%0b paddr=%h mat=%0d hit=%0b want 10000040 1 1", ok, resp_paddr, resp_mat, resp_hit); end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    bit ok;
    dmw0 = 32'hA000_0009; dmw1 = 32'hA200_0009; crmd_plv = 2'd3;
    send(32'hA000_0000, ok);
    total++; if (!ok || resp_paddr !== 32'h0000_0000 || resp_hit !== 1'b1) begin bad++; $display("FAIL prio_dmw0: paddr=%h hit=%0b want 0 1", resp_paddr, resp_hit); end
    @(posedge clk); #1;
    crmd_plv = 2'd1;
    send(32'hA000_0000, ok);
    total++; if (!ok || resp_hit !== 1'b0 || resp_paddr !== 32'hA000_0000 || resp_mat !== 2'b00) begin bad++; $display("FAIL prio_plv1: hit=%0b paddr=%h want 0 a0000000", resp_hit, resp_paddr); end
    total++; if (miss_cnt !== MW'(1)) begin bad++; $display("FAIL prio_miss: got %0d want 1", miss_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit   ok;
    res_t x;
    res_t y;
    crmd_plv = 2'd0; dmw0 = 32'hA000_0011; dmw1 = 32'h0;
    resp_ready = 1'b0;
    send(32'hB000_0040, ok);
    x = last_exp;
    req_valid = 1'b1; req_vaddr = 32'h0000_1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || {resp_hit, resp_mat, resp_paddr} !== {x.hit, x.mat, x.paddr}) begin bad++; $display("FAIL bp_hold%0d: rdy=%0b v=%0b paddr=%h want 0 1 %h", c, req_ready, resp_valid, resp_paddr, x.paddr); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: rdy=%0b want 1", req_ready); end
    y = ref_xlate(req_vaddr, crmd_da, crmd_plv, dmw0, dmw1);
    if (req_ready && !y.hit && exp_miss < MISS_MAX) exp_miss++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || {resp_hit, resp_mat, resp_paddr} !== {y.hit, y.mat, y.paddr} || miss_cnt !== MW'(exp_miss)) begin bad++; $display("FAIL bp_next: v=%0b paddr=%h hit=%0b miss=%0d want 1 %h %0b %0d", resp_valid, resp_paddr, resp_hit, miss_cnt, y.paddr, y.hit, exp_miss); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_drain();
    bit   ok;
    res_t a;
    res_t b;
    crmd_plv = 2'd0; dmw0 = 32'h0; dmw1 = 32'h0;
    resp_ready = 1'b0;
    send(32'h8000_0100, ok);
    a = last_exp;
    csr_wr_req = 1'b1; req_valid = 1'b1; req_vaddr = 32'h8123_4567;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (req_ready !== 1'b0 || csr_wr_grant !== 1'b0 || resp_valid !== 1'b1) begin bad++; $display("FAIL drain_wait%0d: rdy=%0b grant=%0b v=%0b want 0 0 1", c, req_ready, csr_wr_grant, resp_valid); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    total++; if (csr_wr_grant !== 1'b0 || resp_paddr !== a.paddr || resp_hit !== a.hit) begin bad++; $display("FAIL drain_consume: grant=%0b paddr=%h want 0 %h", csr_wr_grant, resp_paddr, a.paddr); end
    @(posedge clk); #1;
    total++; if (csr_wr_grant !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL drain_grant: grant=%0b rdy=%0b v=%0b want 1 0 0", csr_wr_grant, req_ready, resp_valid); end
    @(posedge clk); #1;
    dmw1 = 32'h8600_0021; csr_wr_req = 1'b0;
    #1;
    total++; if (csr_wr_grant !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL drain_post: grant=%0b rdy=%0b want 0 1", csr_wr_grant, req_ready); end
    b = ref_xlate(req_vaddr, crmd_da, crmd_plv, dmw0, dmw1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_paddr !== 32'h6123_4567 || resp_mat !== 2'd2 || resp_hit !== 1'b1 || b.paddr !== 32'h6123_4567) begin bad++; $display("FAIL drain_newcsr: v=%0b paddr=%h mat=%0d hit=%0b want 1 61234567 2 1", resp_valid, resp_paddr, resp_mat, resp_hit); end
    @(posedge clk); #1;
  endtask

  task automatic test_held_write();
    int grants;
    bit prev;
    grants = 0; prev = 1'b0;
    resp_ready = 1'b1; csr_wr_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (csr_wr_grant === 1'b1) grants++;
      total++; if (prev && csr_wr_grant === 1'b1) begin bad++; $display("FAIL held_pulse: grant high two cycles at step %0d", c); end
      prev = (csr_wr_grant === 1'b1);
    end
    csr_wr_req = 1'b0;
    total++; if (grants != 3) begin bad++; $display("FAIL held_count: got %0d grants want 3", grants); end
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL held_ready: rdy=%0b want 1", req_ready); end
  endtask

  task automatic test_sat_reset();
    bit ok;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    exp_miss = 0;
    @(posedge clk); #1;
    crmd_da = 1'b0; crmd_plv = 2'd0; dmw0 = 32'h0; dmw1 = 32'h0; resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      send(32'h4000_0000 + 32'(c), ok);
      total++; if (!ok || miss_cnt !== MW'(exp_miss)) begin bad++; $display("FAIL sat_step%0d: miss=%0d want %0d", c, miss_cnt, exp_miss); end
    end
    total++; if (miss_cnt !== MW'(MISS_MAX)) begin bad++; $display("FAIL sat_final: miss=%0d want %0d", miss_cnt, MISS_MAX); end
    resp_ready = 1'b0;
    @(posedge clk); #1;
    send(32'h4000_0100, ok);
    csr_wr_req = 1'b1;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1 || csr_wr_grant !== 1'b0) begin bad++; $display("FAIL sat_drain: v=%0b grant=%0b want 1 0", resp_valid, csr_wr_grant); end
    #2; rst_n = 1'b0; #1;
    total++; if (resp_valid !== 1'b0 || resp_paddr !== 32'h0 || resp_mat !== 2'b00 || resp_hit !== 1'b0 || csr_wr_grant !== 1'b0 || miss_cnt !== '0) begin bad++; $display("FAIL async_rst: v=%0b paddr=%h mat=%0d hit=%0b grant=%0b miss=%0d want all 0", resp_valid, resp_paddr, resp_mat, resp_hit, csr_wr_grant, miss_cnt); end
    csr_wr_req = 1'b0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL async_rst_run: rdy=%0b want 1", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; exp_miss = 0; resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++; if (csr_wr_grant !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL rst_discard%0d: grant=%0b v=%0b want 0 0", c, csr_wr_grant, resp_valid); end
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    bit   exp_rdy, give, take;
    int   sel;
    resp_ready = 1'b0; req_valid = 1'b0; csr_wr_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin dmw0 = $urandom; dmw1 = $urandom; end
      req_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 2);
      req_vaddr = $urandom;
      if (sel == 0)      req_vaddr[31:29] = dmw0[31:29];
      else if (sel == 1) req_vaddr[31:29] = dmw1[31:29];
      crmd_plv = 2'($urandom_range(0, 3));
      crmd_da = ($urandom_range(0, 7) == 0);
      crmd_pg = !crmd_da;
      resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() == 0) || resp_ready;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready%0d: got %0b want %0b", i, req_ready, exp_rdy); end
      give = resp_valid && resp_ready;
      take = req_valid && req_ready;
      if (give) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious%0d: response with nothing outstanding", i);
        end else begin
          e = q.pop_front();
          if ({resp_hit, resp_mat, resp_paddr} !== {e.hit, e.mat, e.paddr}) begin bad++; $display("FAIL rnd_resp%0d: hit=%0b mat=%0d paddr=%h want %0b %0d %h", i, resp_hit, resp_mat, resp_paddr, e.hit, e.mat, e.paddr); end
        end
      end
      if (take) begin
        e = ref_xlate(req_vaddr, crmd_da, crmd_plv, dmw0, dmw1);
        q.push_back(e);
        if (!e.hit && exp_miss < MISS_MAX) exp_miss++;
      end
      @(posedge clk); #1;
      total++; if (resp_valid !== (q.size() != 0) || miss_cnt !== MW'(exp_miss)) begin bad++; $display("FAIL rnd_state%0d: v=%0b miss=%0d want %0b %0d", i, resp_valid, miss_cnt, (q.size() != 0), exp_miss); end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_da();
    test_dmw_hit();
    test_priority();
    test_backpressure();
    test_write_drain();
    test_held_write();
    test_sat_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
